voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
Polyphonic note scheduler that owns a bank of NUM_VOICES voice instances. It accepts note-on and note-off events over a valid/ready handshake and drives each voice's gate and tone_freq inputs. It assigns free voices lowest-index-first and steals a sounding voice round-robin when all are busy. It sits between the event source (pin/MIDI decoder) and the voice bank, whose outputs feed the mixer tree and pdm_dac.

Parameters:
NUM_VOICES, 3, number of voices managed (2..16)
FREQ_BITS, 16, width of the tone_freq word per voice
NOTE_BITS, 7, width of the note identifier
GAP_CYCLES, 4, gate-low cycles inserted on retrigger (used only with the optional feature)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
ev_valid  input  1  event present
ev_ready  output  1  allocator can accept an event
ev_note_on  input  1  1 = note-on, 0 = note-off
ev_note  input  NOTE_BITS  note identifier
ev_freq  input  FREQ_BITS  phase increment for note-on, (16777216*f)/1e6; ignored for note-off
gate  output  NUM_VOICES  per-voice gate to voice.gate
tone_freq  output  NUM_VOICES*FREQ_BITS  voice i occupies bits [i*FREQ_BITS +: FREQ_BITS]
active_count  output  clog2(NUM_VOICES+1)  number of gates currently high
steal_pulse  output  1  one-cycle pulse when a sounding voice is stolen

Behaviour:
- Reset: gate=0, tone_freq=0, per-voice note tags=0, steal_ptr=0, active_count=0, steal_pulse=0, state=IDLE, ev_ready=1. Reset asserted mid-scan aborts the event with no output change beyond the reset values.
- States:
  - IDLE: ev_ready=1. On ev_valid&ev_ready, latch on/note/freq, clear the scan registers, go to SCAN.
  - SCAN: ev_ready=0. Inspect voice idx = 0..NUM_VOICES-1, one per cycle. Record match_idx as the lowest idx with gate=1 and tag==note. Record free_idx as the lowest idx with gate=0. After the last idx, go to APPLY.
  - APPLY: one cycle, apply the decision (below), then go to IDLE (or GAP with the feature).
- Latency: event accepted at edge 0; outputs change at edge NUM_VOICES+1; ev_ready is high again in the cycle after that edge. Events spaced NUM_VOICES+2 cycles apart are all accepted without stall.
- Note-on decision:
  - match found: update that voice's tone_freq; gate stays 1.
  - else free found: tag=note, tone_freq=freq, gate=1.
  - else steal voice steal_ptr: tag/freq overwritten, gate stays 1, steal_pulse=1 for one cycle. steal_ptr increments and wraps NUM_VOICES-1 to 0.
- Note-off decision:
  - match found: gate=0; tone_freq and tag are retained so the release phase keeps its pitch.
  - no match: event dropped, no output change.
- steal_ptr advances only on a steal, never on free allocation.
- active_count is registered and equals popcount(gate) after every edge.
- ev_valid may drop while ev_ready=0 without effect. Event fields are sampled only at acceptance.
- Simultaneous rst and ev_valid: rst wins, event lost.

Optional Feature:
Macro VOICE_ALLOCATOR_RETRIGGER_EN.
- Defined: on a steal, or on a note-on matching an already sounding voice, APPLY drives that voice's gate=0 and enters state GAP for GAP_CYCLES cycles (ev_ready=0). On GAP exit, gate=1 is set together with the new freq/tag, so the envelope generator sees a fresh rising edge and restarts attack. steal_pulse still fires in APPLY.
- Undefined: GAP state absent; behaviour as above, with no retrigger.

Decomposition:
- Shared package voice_alloc_pkg:
  - state encoding constants (ST_IDLE, ST_SCAN, ST_APPLY, ST_GAP)
  - event field width localparams (NOTE_BITS, FREQ_BITS defaults)
  - function for voice-index width clog2
- One natural sub-module, voice_alloc_slot: holds one voice's gate/tag/freq registers with write-enable, clear and retrigger inputs, plus the tag-compare output. It is instantiated NUM_VOICES times via generate.

Test Plan:
1. Reset, then note-on C(60,4389), E(64,5530), G(67,6577) spaced 5 cycles -> gate=3'b111, tone_freq={6577,5530,4389}, active_count=3, steal_pulse never high.
2. Full bank, note-on (72,8779) -> voice 0 stolen: tone_freq[0]=8779, steal_pulse one cycle; a second note-on (74,9853) steals voice 1; the fourth steal wraps to voice 0.
3. Note-off 64 -> gate=3'b101, tone_freq[1] still 5530. Note-off 50 (no match) -> no change, ev_ready back after NUM_VOICES+2 cycles.
4. Note-on 60 while 60 sounding with freq 4400 -> voice 0 freq=4400, gate unchanged (macro off). With macro on, gate[0] low exactly GAP_CYCLES=4 cycles, then high.
5. Hold ev_valid=1 continuously with back-to-back events -> exactly one event accepted per NUM_VOICES+2 cycles; none lost or duplicated.
6. Assert rst during SCAN of a note-on -> all outputs 0 asynchronously, ev_ready=1 after release, event not applied.

Source files
------------

// File: rtl/voice_alloc_pkg.sv
// voice_alloc_pkg
// Shared definitions for the voice allocator slice: FSM state encoding,
// default event field widths and the voice-index width helper.
// Optional feature macro used by the slice: VOICE_ALLOCATOR_RETRIGGER_EN
// (the ST_GAP encoding is always present; only the allocator FSM uses it,
// and only when the macro is defined).

package voice_alloc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_APPLY = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam int NOTE_BITS_DEF = 7;
   localparam int FREQ_BITS_DEF = 16;

   // Width of a voice index; never narrower than one bit.
   function automatic int idx_bits(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if
// Note event channel from the event source (pin/MIDI decoder) into the
// voice allocator.
//   ev_valid   : event present
//   ev_ready   : allocator can accept an event
//   ev_note_on : 1 = note-on, 0 = note-off
//   ev_note    : note identifier
//   ev_freq    : phase increment for note-on, ignored for note-off
// Modports: master = event source, slave = allocator.

interface voice_allocator_if
   import voice_alloc_pkg::*;
#(
   parameter int NOTE_BITS = NOTE_BITS_DEF,
   parameter int FREQ_BITS = FREQ_BITS_DEF
);

   // Handshake: an event transfers on a rising clk edge where ev_valid and
   // ev_ready are both high. The fields are sampled only on that edge; the
   // source may change or withdraw them freely while ev_ready is low.
   logic                 ev_valid;
   logic                 ev_ready;
   logic                 ev_note_on;
   logic [NOTE_BITS-1:0] ev_note;
   logic [FREQ_BITS-1:0] ev_freq;

   modport master (output ev_valid, ev_note_on, ev_note, ev_freq,
                   input  ev_ready);

   modport slave  (input  ev_valid, ev_note_on, ev_note, ev_freq,
                   output ev_ready);

endinterface

// File: rtl/voice_alloc_slot.sv
// voice_alloc_slot
// State of one voice: gate, note tag and tone frequency, plus the compare
// that tells the allocator whether this voice is sounding the given note.
//   clk, rst : clock, asynchronous active-high reset
//   wr_en    : load note/freq and raise gate
//   clr      : drop gate (note-off), tag and freq retained
//   retrig   : drop gate ahead of a re-attack, tag and freq retained
//   note     : note to load and to compare against
//   freq_in  : frequency to load
//   gate     : voice gate
//   freq     : voice tone frequency
//   match    : voice is sounding and its tag equals note

module voice_alloc_slot
   import voice_alloc_pkg::*;
#(
   parameter int NOTE_BITS = NOTE_BITS_DEF,
   parameter int FREQ_BITS = FREQ_BITS_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic                 clr,
   input  logic                 retrig,
   input  logic [NOTE_BITS-1:0] note,
   input  logic [FREQ_BITS-1:0] freq_in,
   output logic                 gate,
   output logic [FREQ_BITS-1:0] freq,
   output logic                 match
);

   logic [NOTE_BITS-1:0] tag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate <= 1'b0;
         tag  <= '0;
         freq <= '0;
      end else if (wr_en) begin
         gate <= 1'b1;
         tag  <= note;
         freq <= freq_in;
      end else if (clr || retrig) begin
         gate <= 1'b0;
      end
   end

   assign match = gate && (tag == note);

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic note scheduler for a bank of NUM_VOICES voices. Note-on takes
// the voice already sounding that note, else the lowest free voice, else
// steals a sounding voice round-robin. Note-off releases the matching voice.
// Each event is scanned one voice per cycle, then applied in one cycle.
// Optional: VOICE_ALLOCATOR_RETRIGGER_EN drops the gate for GAP_CYCLES on a
// steal or re-struck note so the envelope restarts its attack.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   ev           : note event channel (slave side)
//   gate         : per-voice gate
//   tone_freq    : voice i at [i*FREQ_BITS +: FREQ_BITS]
//   active_count : number of gates high
//   steal_pulse  : one-cycle pulse when a sounding voice is stolen
//   fsm_state    : current allocator state (debug)

module voice_allocator
   import voice_alloc_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int FREQ_BITS  = FREQ_BITS_DEF,
   parameter int NOTE_BITS  = NOTE_BITS_DEF
`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
   // Exists only when the retrigger gap is built in.
   , parameter int GAP_CYCLES = 4
`endif
)(
   input  logic                            clk,
   input  logic                            rst,
   voice_allocator_if.slave                ev,
   output logic [NUM_VOICES-1:0]           gate,
   output logic [NUM_VOICES*FREQ_BITS-1:0] tone_freq,
   output logic [$clog2(NUM_VOICES+1)-1:0] active_count,
   output logic                            steal_pulse,
   output state_t                          fsm_state
);

   localparam int IW = idx_bits(NUM_VOICES);
   localparam int CW = $clog2(NUM_VOICES + 1);
   localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

   state_t               state;
   logic                 on_q;
   logic [NOTE_BITS-1:0] note_q;
   logic [FREQ_BITS-1:0] freq_q;
   logic [IW-1:0]        idx;
   logic [IW-1:0]        match_idx;
   logic [IW-1:0]        free_idx;
   logic [IW-1:0]        steal_ptr;
   logic                 match_found;
   logic                 free_found;

   logic [IW-1:0]         tgt;
   logic                  steal;
   logic [NUM_VOICES-1:0] wr_en;
   logic [NUM_VOICES-1:0] clr;
   logic [NUM_VOICES-1:0] retrig;
   logic [NUM_VOICES-1:0] match;
   logic [NUM_VOICES-1:0] gate_nxt;
   logic [CW-1:0]         cnt_nxt;

`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
   localparam int GW = $clog2(GAP_CYCLES + 1);
   logic [GW-1:0] gap_cnt;
   logic [IW-1:0] tgt_q;
`endif

   assign ev.ev_ready = (state == ST_IDLE);
   assign fsm_state   = state;

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
      voice_alloc_slot #(
         .NOTE_BITS(NOTE_BITS),
         .FREQ_BITS(FREQ_BITS)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (wr_en[i]),
         .clr     (clr[i]),
         .retrig  (retrig[i]),
         .note    (note_q),
         .freq_in (freq_q),
         .gate    (gate[i]),
         .freq    (tone_freq[i*FREQ_BITS +: FREQ_BITS]),
         .match   (match[i])
      );
   end

   // Decision decode: slot strobes are only raised in APPLY (and at GAP exit).
   always_comb begin
      wr_en  = '0;
      clr    = '0;
      retrig = '0;
      steal  = 1'b0;
      tgt    = match_found ? match_idx : (free_found ? free_idx : steal_ptr);
      if (state == ST_APPLY) begin
         if (on_q) begin
            steal = !match_found && !free_found;
`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
            if (match_found || steal) retrig[tgt] = 1'b1;
            else                      wr_en[tgt]  = 1'b1;
`else
            wr_en[tgt] = 1'b1;
`endif
         end else if (match_found) begin
            clr[tgt] = 1'b1;
         end
      end
`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
      if (state == ST_GAP && gap_cnt == '0) wr_en[tgt_q] = 1'b1;
`endif
   end

   // Gate vector the slots will hold after this edge, so active_count can be
   // registered in step with the gates.
   always_comb begin
      cnt_nxt = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         gate_nxt[i] = wr_en[i] ? 1'b1 : ((clr[i] || retrig[i]) ? 1'b0 : gate[i]);
         cnt_nxt     = cnt_nxt + CW'(gate_nxt[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         on_q         <= 1'b0;
         note_q       <= '0;
         freq_q       <= '0;
         idx          <= '0;
         match_idx    <= '0;
         free_idx     <= '0;
         match_found  <= 1'b0;
         free_found   <= 1'b0;
         steal_ptr    <= '0;
         steal_pulse  <= 1'b0;
         active_count <= '0;
`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
         gap_cnt      <= '0;
         tgt_q        <= '0;
`endif
      end else begin
         steal_pulse  <= 1'b0;
         active_count <= cnt_nxt;
         case (state)
            ST_IDLE: begin
               if (ev.ev_valid) begin
                  on_q        <= ev.ev_note_on;
                  note_q      <= ev.ev_note;
                  freq_q      <= ev.ev_freq;
                  idx         <= '0;
                  match_found <= 1'b0;
                  free_found  <= 1'b0;
                  match_idx   <= '0;
                  free_idx    <= '0;
                  state       <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // First hit wins, giving lowest-index priority.
               if (!match_found && match[idx]) begin
                  match_found <= 1'b1;
                  match_idx   <= idx;
               end
               if (!free_found && !gate[idx]) begin
                  free_found <= 1'b1;
                  free_idx   <= idx;
               end
               if (idx == LAST) state <= ST_APPLY;
               else             idx   <= idx + 1'b1;
            end
            ST_APPLY: begin
               if (steal) begin
                  steal_pulse <= 1'b1;
                  steal_ptr   <= (steal_ptr == LAST) ? '0 : steal_ptr + 1'b1;
               end
`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
               if (on_q && (match_found || steal)) begin
                  tgt_q   <= tgt;
                  gap_cnt <= GW'(GAP_CYCLES - 1);
                  state   <= ST_GAP;
               end else begin
                  state <= ST_IDLE;
               end
`else
               state <= ST_IDLE;
`endif
            end
`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
            ST_GAP: begin
               if (gap_cnt == '0) state   <= ST_IDLE;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Self-checking bench for voice_allocator: a reference model of the voice
// bank pushes the expected {steal, gate, tone_freq} per event into exp_q,
// and each scenario task pops and compares once the allocator is ready again.

module tb_voice_allocator;
   import voice_alloc_pkg::*;

   localparam int NV  = 3;
   localparam int FB  = 16;
   localparam int NB  = 7;
   localparam int GAP = 4;
   localparam int CW  = $clog2(NV + 1);
   localparam int W   = 1 + NV + NV * FB;

   logic              clk = 1'b0;
   logic              rst;
   logic [NV-1:0]     gate;
   logic [NV*FB-1:0]  tone_freq;
   logic [CW-1:0]     active_count;
   logic              steal_pulse;
   state_t            fsm_state;

   voice_allocator_if #(.NOTE_BITS(NB), .FREQ_BITS(FB)) evif ();

   voice_allocator #(
      .NUM_VOICES(NV),
      .FREQ_BITS (FB),
      .NOTE_BITS (NB)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .ev           (evif.slave),
      .gate         (gate),
      .tone_freq    (tone_freq),
      .active_count (active_count),
      .steal_pulse  (steal_pulse),
      .fsm_state    (fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- scoreboard / model ----------------
   logic [W-1:0]    exp_q[$];
   logic [NV-1:0]   m_gate;
   logic [NB-1:0]   m_tag[NV];
   logic [FB-1:0]   m_freq[NV];
   int              m_ptr;

   function automatic logic [NV*FB-1:0] pack_freq();
      logic [NV*FB-1:0] v;
      v = '0;
      for (int i = 0; i < NV; i++) v[i*FB +: FB] = m_freq[i];
      return v;
   endfunction

   task automatic model_reset();
      m_gate = '0;
      m_ptr  = 0;
      for (int i = 0; i < NV; i++) begin
         m_tag[i]  = '0;
         m_freq[i] = '0;
      end
      exp_q.delete();
   endtask

   task automatic model_event(input bit on, input logic [NB-1:0] note,
                              input logic [FB-1:0] freq,
                              output bit steal, output bit retrig, output int tgt);
      int mi, fi;
      mi = -1; fi = -1;
      for (int i = 0; i < NV; i++) begin
         if (mi < 0 && m_gate[i] && m_tag[i] == note) mi = i;
         if (fi < 0 && !m_gate[i]) fi = i;
      end
      steal = 0; retrig = 0; tgt = 0;
      if (on) begin
         if (mi >= 0) begin
            tgt = mi; m_freq[tgt] = freq; retrig = 1;
         end else if (fi >= 0) begin
            tgt = fi; m_tag[tgt] = note; m_freq[tgt] = freq; m_gate[tgt] = 1'b1;
         end else begin
            tgt = m_ptr; m_tag[tgt] = note; m_freq[tgt] = freq;
            steal = 1; retrig = 1; m_ptr = (m_ptr + 1) % NV;
         end
      end else if (mi >= 0) begin
         tgt = mi; m_gate[tgt] = 1'b0;
      end
      exp_q.push_back({steal, m_gate, pack_freq()});
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      evif.ev_valid   = 1'b0;
      evif.ev_note_on = 1'b0;
      evif.ev_note    = '0;
      evif.ev_freq    = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Drives one event, waits for ev_ready to return and checks the result.
   task automatic send_event(input bit on, input logic [NB-1:0] note,
                             input logic [FB-1:0] freq);
      bit steal, retrig;
      int tgt, lat, low, pulse_cnt, pulse_lat, exp_lat;
      logic [W-1:0] e;
      evif.ev_valid   = 1'b1;
      evif.ev_note_on = on;
      evif.ev_note    = note;
      evif.ev_freq    = freq;
      @(posedge clk); #1;
      // Scramble the fields: only the acceptance edge may sample them.
      evif.ev_valid   = 1'b0;
      evif.ev_note_on = 1'($urandom_range(0, 1));
      evif.ev_note    = NB'($urandom_range(0, 127));
      evif.ev_freq    = FB'($urandom_range(0, 65535));
      model_event(on, note, freq, steal, retrig, tgt);
      lat = 0; low = 0; pulse_cnt = 0; pulse_lat = 0;
      while (evif.ev_ready !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (steal_pulse === 1'b1) begin pulse_cnt++; pulse_lat = lat; end
         if (retrig && gate[tgt] === 1'b0) low++;
      end
      exp_lat = NV + 1;
`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
      if (retrig) exp_lat += GAP;
`endif
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL latency note=%0d: got %0d edges, expected %0d", note, lat, exp_lat);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty note=%0d: got 0 entries, expected 1", note);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (gate !== e[NV*FB +: NV]) begin
            errors++;
            $display("FAIL gate note=%0d: got %b, expected %b", note, gate, e[NV*FB +: NV]);
         end
         checks++;
         if (tone_freq !== e[NV*FB-1:0]) begin
            errors++;
            $display("FAIL tone_freq note=%0d: got %h, expected %h", note, tone_freq, e[NV*FB-1:0]);
         end
         checks++;
         if (active_count !== CW'($countones(e[NV*FB +: NV]))) begin
            errors++;
            $display("FAIL active_count note=%0d: got %0d, expected %0d", note, active_count,
                     $countones(e[NV*FB +: NV]));
         end
         checks++;
         if (pulse_cnt != int'(e[W-1])) begin
            errors++;
            $display("FAIL steal_pulse_count note=%0d: got %0d, expected %0d", note, pulse_cnt, e[W-1]);
         end
      end
      if (steal) begin
         checks++;
         if (pulse_lat != NV + 1) begin
            errors++;
            $display("FAIL steal_pulse_edge note=%0d: got %0d, expected %0d", note, pulse_lat, NV + 1);
         end
      end
      if (retrig) begin
         exp_lat = 0;
`ifdef VOICE_ALLOCATOR_RETRIGGER_EN
         exp_lat = GAP;
`endif
         checks++;
         if (low != exp_lat) begin
            errors++;
            $display("FAIL gate_low_cycles note=%0d: got %0d, expected %0d", note, low, exp_lat);
         end
      end
   endtask

   task automatic fill_chord();
      send_event(1'b1, 7'd60, 16'd4389);
      send_event(1'b1, 7'd64, 16'd5530);
      send_event(1'b1, 7'd67, 16'd6577);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      checks++;
      if (gate !== '0 || tone_freq !== '0 || active_count !== '0 || steal_pulse !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got gate=%b freq=%h cnt=%0d steal=%b, expected all 0",
                  gate, tone_freq, active_count, steal_pulse);
      end
      checks++;
      if (evif.ev_ready !== 1'b1 || fsm_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_ready: got ready=%b state=%0d, expected ready=1 state=%0d",
                  evif.ev_ready, fsm_state, ST_IDLE);
      end
   endtask

   task automatic test_fill();
      do_reset();
      fill_chord();
      checks++;
      if (tone_freq !== {16'd6577, 16'd5530, 16'd4389} || gate !== 3'b111) begin
         errors++;
         $display("FAIL chord: got gate=%b freq=%h, expected 111 %h", gate, tone_freq,
                  {16'd6577, 16'd5530, 16'd4389});
      end
   endtask

   task automatic test_steal();
      // Bank is full from test_fill; four steals walk 0,1,2 and wrap to 0.
      send_event(1'b1, 7'd72, 16'd8779);
      send_event(1'b1, 7'd74, 16'd9853);
      send_event(1'b1, 7'd76, 16'd11000);
      send_event(1'b1, 7'd77, 16'd11700);
      @(posedge clk); #1;
      checks++;
      if (steal_pulse !== 1'b0) begin
         errors++;
         $display("FAIL steal_pulse_width: got %b, expected 0", steal_pulse);
      end
   endtask

   task automatic test_note_off();
      do_reset();
      fill_chord();
      send_event(1'b0, 7'd64, 16'd0);
      send_event(1'b0, 7'd50, 16'd1234);
      checks++;
      if (gate !== 3'b101 || tone_freq[FB +: FB] !== 16'd5530) begin
         errors++;
         $display("FAIL note_off_release: got gate=%b f1=%0d, expected 101 5530",
                  gate, tone_freq[FB +: FB]);
      end
   endtask

   task automatic test_match_retrigger();
      do_reset();
      fill_chord();
      send_event(1'b1, 7'd60, 16'd4400);
   endtask

   task automatic test_back_to_back();
      bit            on_t[6]   = '{1, 1, 0, 1, 0, 1};
      logic [NB-1:0] note_t[6] = '{7'd60, 7'd64, 7'd60, 7'd67, 7'd64, 7'd62};
      logic [FB-1:0] freq_t[6] = '{16'd4389, 16'd5530, 16'd0, 16'd6577, 16'd0, 16'd5000};
      int j, cyc, last_acc;
      bit rb, vb, st, rt;
      int tg;
      logic [W-1:0] e;
      do_reset();
      j = 0; cyc = 0; last_acc = -1;
      evif.ev_valid = 1'b1; evif.ev_note_on = on_t[0];
      evif.ev_note = note_t[0]; evif.ev_freq = freq_t[0];
      while ((j < 6 || exp_q.size() > 0) && cyc < 300) begin
         rb = evif.ev_ready; vb = evif.ev_valid;
         @(posedge clk); #1;
         cyc++;
         if (!rb && evif.ev_ready === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (gate !== e[NV*FB +: NV] || tone_freq !== e[NV*FB-1:0]) begin
               errors++;
               $display("FAIL b2b_result: got gate=%b freq=%h, expected %b %h", gate, tone_freq,
                        e[NV*FB +: NV], e[NV*FB-1:0]);
            end
         end
         if (rb && vb) begin
            model_event(on_t[j], note_t[j], freq_t[j], st, rt, tg);
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != NV + 2) begin
                  errors++;
                  $display("FAIL b2b_spacing ev=%0d: got %0d cycles, expected %0d", j, cyc - last_acc, NV + 2);
               end
            end
            last_acc = cyc;
            j++;
            if (j < 6) begin
               evif.ev_note_on = on_t[j]; evif.ev_note = note_t[j]; evif.ev_freq = freq_t[j];
            end else begin
               evif.ev_valid = 1'b0;
            end
         end
      end
      evif.ev_valid = 1'b0;
      checks++;
      if (j != 6 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: got %0d accepted %0d pending, expected 6 accepted 0 pending",
                  j, exp_q.size());
      end
      checks++;
      if (gate !== 3'b011 || active_count !== CW'(2)) begin
         errors++;
         $display("FAIL b2b_final: got gate=%b cnt=%0d, expected 011 2", gate, active_count);
      end
   endtask

   task automatic test_reset_mid_scan();
      do_reset();
      send_event(1'b1, 7'd60, 16'd4389);
      evif.ev_valid = 1'b1; evif.ev_note_on = 1'b1;
      evif.ev_note = 7'd64; evif.ev_freq = 16'd5530;
      @(posedge clk); #1;
      evif.ev_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (fsm_state !== ST_SCAN) begin
         errors++;
         $display("FAIL mid_scan_state: got %0d, expected %0d", fsm_state, ST_SCAN);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (gate !== '0 || tone_freq !== '0 || active_count !== '0 || evif.ev_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: got gate=%b freq=%h cnt=%0d ready=%b, expected 0 0 0 1",
                  gate, tone_freq, active_count, evif.ev_ready);
      end
      // Simultaneous rst and ev_valid: the event must be lost.
      evif.ev_valid = 1'b1; evif.ev_note = 7'd67; evif.ev_freq = 16'd6577;
      @(posedge clk); #1;
      evif.ev_valid = 1'b0;
      rst = 1'b0;
      model_reset();
      repeat (NV + 3) @(posedge clk);
      #1;
      checks++;
      if (gate !== '0 || tone_freq !== '0 || fsm_state !== ST_IDLE || evif.ev_ready !== 1'b1) begin
         errors++;
         $display("FAIL after_reset_release: got gate=%b freq=%h state=%0d ready=%b, expected 0 0 %0d 1",
                  gate, tone_freq, fsm_state, evif.ev_ready, ST_IDLE);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      rst = 1'b1;
      evif.ev_valid = 1'b0;
      test_reset();
      test_fill();
      test_steal();
      test_note_off();
      test_match_retrigger();
      test_back_to_back();
      test_reset_mid_scan();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
